// File: rtl/multichannel_frame_sequencer_if.sv
// Bus bundle for the multichannel frame sequencer: CPU load/store port,
// control/status and the spectral engine stream.
interface multichannel_frame_sequencer_if #(
    parameter int SAMPLE_W = 16,
    parameter int WORD_W   = 512,
    parameter int FRAME    = 2048,
    parameter int CHANNELS = 2
);
    localparam int SPW   = WORD_W / SAMPLE_W;
    localparam int WORDS = FRAME / SPW;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Control / status
    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [CW-1:0]         cur_ch;

    // CPU load port (into load bank) and read port (from result bank)
    logic                  wr_en;
    logic [CW-1:0]         wr_ch;
    logic [IW-1:0]         wr_index;
    logic [WORD_W-1:0]     wr_data;
    logic [CW-1:0]         rd_ch;
    logic [IW-1:0]         rd_index;
    logic [WORD_W-1:0]     rd_data;

    // Spectral engine stream
    logic                  eng_ce;
    logic [2*SAMPLE_W-1:0] eng_sample;
    logic                  eng_sync;
    logic [2*SAMPLE_W-1:0] eng_result;

    modport master (
        output start, abort, wr_en, wr_ch, wr_index, wr_data, rd_ch, rd_index,
               eng_sync, eng_result,
        input  busy, done, error, cur_ch, rd_data, eng_ce, eng_sample
    );

    modport slave (
        input  start, abort, wr_en, wr_ch, wr_index, wr_data, rd_ch, rd_index,
               eng_sync, eng_result,
        output busy, done, error, cur_ch, rd_data, eng_ce, eng_sample
    );
endinterface

// File: rtl/multichannel_frame_sequencer.sv
// Multichannel frame sequencer: streams each channel's double-buffered input
// frame through an external spectral engine and collects the real part of the
// engine output into a double-buffered result store.
module multichannel_frame_sequencer #(
    parameter int SAMPLE_W     = 16,
    parameter int WORD_W       = 512,
    parameter int FRAME        = 2048,
    parameter int CHANNELS     = 2,
    parameter int SYNC_TIMEOUT = 8192
) (
    input  logic clk,
    input  logic rst_n,
    multichannel_frame_sequencer_if.slave bus
);
    localparam int SPW       = WORD_W / SAMPLE_W;
    localparam int WORDS     = FRAME / SPW;
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int FW        = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int TW        = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam int IN_DEPTH  = 2 * CHANNELS * WORDS;
    localparam int OUT_DEPTH = 2 * CHANNELS * FRAME;
    localparam int IAW       = $clog2(IN_DEPTH);
    localparam int OAW       = $clog2(OUT_DEPTH);

    typedef enum logic [2:0] {IDLE, FEED, WAIT_SYNC, COLLECT, DONE} state_t;

    state_t          state_reg;
    logic            load_bank_reg;
    logic            res_bank_reg;
    logic            proc_bank_reg;
    logic [CW-1:0]   cur_ch_reg;
    logic [FW-1:0]   cnt_reg;
    logic [TW-1:0]   wait_cnt_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            error_reg;
    logic            eng_ce_reg;

    // Input frames are held as whole CPU words, results as single samples
    logic [WORD_W-1:0]   in_mem  [IN_DEPTH];
    logic [SAMPLE_W-1:0] out_mem [OUT_DEPTH];

    function automatic logic [IAW-1:0] in_addr(input logic bank, input logic [CW-1:0] ch,
                                               input logic [IW-1:0] word);
        return IAW'((int'(bank) * CHANNELS + int'(ch)) * WORDS + int'(word));
    endfunction

    function automatic logic [OAW-1:0] out_addr(input logic bank, input logic [CW-1:0] ch,
                                                 input int sample);
        return OAW'((int'(bank) * CHANNELS + int'(ch)) * FRAME + sample);
    endfunction

    // Feed path: pick sample cnt of the channel being processed
    logic [WORD_W-1:0]   feed_word;
    logic [SAMPLE_W-1:0] feed_sample;
    assign feed_word   = in_mem[in_addr(proc_bank_reg, cur_ch_reg, IW'(int'(cnt_reg) / SPW))];
    assign feed_sample = feed_word[(int'(cnt_reg) % SPW) * SAMPLE_W +: SAMPLE_W];

    // Collect path: the sync beat is index 0, later beats use cnt
    logic          collect_we;
    logic [FW-1:0] collect_idx;
    assign collect_we  = (state_reg == COLLECT) || ((state_reg == WAIT_SYNC) && bus.eng_sync);
    assign collect_idx = (state_reg == COLLECT) ? cnt_reg : '0;

    // Imaginary half of the engine result is deliberately dropped
    logic unused_imag;
    assign unused_imag = ^bus.eng_result[SAMPLE_W-1:0];

    // CPU writes always target the load bank (pre-toggle value on a start edge)
    always_ff @(posedge clk) begin
        if (bus.wr_en)
            in_mem[in_addr(load_bank_reg, bus.wr_ch, bus.wr_index)] <= bus.wr_data;
    end

    // Engine results land in the bank hidden from the CPU until completion
    always_ff @(posedge clk) begin
        if (collect_we)
            out_mem[out_addr(~res_bank_reg, cur_ch_reg, int'(collect_idx))] <=
                bus.eng_result[2*SAMPLE_W-1:SAMPLE_W];
    end

    // Control FSM: bank pointers, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            load_bank_reg <= 1'b0;
            res_bank_reg  <= 1'b0;
            proc_bank_reg <= 1'b0;
            cur_ch_reg    <= '0;
            cnt_reg       <= '0;
            wait_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            eng_ce_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if ((state_reg != IDLE) && bus.abort) begin
                // Abort leaves result bank and error flag untouched
                state_reg  <= IDLE;
                busy_reg   <= 1'b0;
                eng_ce_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            proc_bank_reg <= load_bank_reg;
                            load_bank_reg <= ~load_bank_reg;
                            error_reg     <= 1'b0;
                            cur_ch_reg    <= '0;
                            cnt_reg       <= '0;
                            busy_reg      <= 1'b1;
                            eng_ce_reg    <= 1'b1;
                            state_reg     <= FEED;
                        end
                    end
                    FEED: begin
                        // Sync seen here belongs to the previous frame and is ignored
                        if (cnt_reg == FW'(FRAME - 1)) begin
                            wait_cnt_reg <= '0;
                            state_reg    <= WAIT_SYNC;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    WAIT_SYNC: begin
                        if (bus.eng_sync) begin
                            cnt_reg   <= FW'(1);
                            state_reg <= COLLECT;
                        end else if (wait_cnt_reg == TW'(SYNC_TIMEOUT - 1)) begin
                            error_reg  <= 1'b1;
                            busy_reg   <= 1'b0;
                            eng_ce_reg <= 1'b0;
                            state_reg  <= IDLE;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        end
                    end
                    COLLECT: begin
                        if (cnt_reg == FW'(FRAME - 1)) begin
                            if (cur_ch_reg == CW'(CHANNELS - 1)) begin
                                done_reg   <= 1'b1;
                                eng_ce_reg <= 1'b0;
                                state_reg  <= DONE;
                            end else begin
                                cur_ch_reg <= cur_ch_reg + 1'b1;
                                cnt_reg    <= '0;
                                state_reg  <= FEED;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    DONE: begin
                        res_bank_reg <= ~res_bank_reg;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end
                    default: begin
                        busy_reg   <= 1'b0;
                        eng_ce_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                endcase
            end
        end
    end

    // CPU read port: one word of the visible result bank, lane by lane
    generate
        for (genvar gi = 0; gi < SPW; gi++) begin : g_rd_lane
            assign bus.rd_data[gi*SAMPLE_W +: SAMPLE_W] =
                out_mem[out_addr(res_bank_reg, bus.rd_ch, int'(bus.rd_index) * SPW + gi)];
        end
    endgenerate

    assign bus.eng_sample = (state_reg == FEED) ? {feed_sample, {SAMPLE_W{1'b0}}} : '0;
    assign bus.eng_ce     = eng_ce_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.error      = error_reg;
    assign bus.cur_ch     = cur_ch_reg;
endmodule

// File: tb/tb_multichannel_frame_sequencer.sv
// Bench for multichannel_frame_sequencer: a frame-echo engine model, a
// timeline reference model and a per-cycle compare process, driven by
// directed scenarios (loopback, double buffering, abort, timeout, reset).
module tb_multichannel_frame_sequencer;
    localparam int SAMPLE_W     = 16;
    localparam int WORD_W       = 64;
    localparam int FRAME        = 64;
    localparam int CHANNELS     = 2;
    localparam int SYNC_TIMEOUT = 20;
    localparam int SPW          = WORD_W / SAMPLE_W;
    localparam int WORDS        = FRAME / SPW;
    localparam int CW           = 1;
    localparam int IW           = 4;
    localparam int LAT          = 10;
    localparam int PERIOD       = 2 * FRAME + LAT;          // feed + 11 wait + 63 collect
    localparam int RUN_LEN      = CHANNELS * PERIOD + 1;    // busy cycles incl. DONE
    localparam int TO_LEN       = FRAME + SYNC_TIMEOUT;     // busy cycles of a timeout run

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multichannel_frame_sequencer_if #(
        .SAMPLE_W(SAMPLE_W), .WORD_W(WORD_W), .FRAME(FRAME), .CHANNELS(CHANNELS)
    ) bus ();

    multichannel_frame_sequencer #(
        .SAMPLE_W(SAMPLE_W), .WORD_W(WORD_W), .FRAME(FRAME),
        .CHANNELS(CHANNELS), .SYNC_TIMEOUT(SYNC_TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- engine model: frame in, echoed frame out ----------------
    int eng_mode = 0;   // 0: echo with sync, 1: never syncs
    int c_reg    = 0;
    logic [SAMPLE_W-1:0] eng_buf [FRAME];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) c_reg <= 0;
        else if (bus.eng_ce) begin
            if (c_reg < FRAME) eng_buf[c_reg] <= bus.eng_sample[2*SAMPLE_W-1:SAMPLE_W];
            c_reg <= (c_reg == PERIOD - 1) ? 0 : c_reg + 1;
        end else c_reg <= 0;
    end

    always_comb begin
        bus.eng_sync   = 1'b0;
        bus.eng_result = '0;
        if (bus.eng_ce && eng_mode == 0) begin
            if (c_reg == 5) bus.eng_sync = 1'b1;   // stale sync during feed
            if (c_reg >= FRAME + LAT) begin
                bus.eng_sync   = (c_reg == FRAME + LAT);
                bus.eng_result = {eng_buf[c_reg - FRAME - LAT], 16'hBEEF};
            end
        end
    end

    // ---------------- reference model (timeline level) ----------------
    logic [SAMPLE_W-1:0] m_in  [2][CHANNELS][FRAME];
    logic [SAMPLE_W-1:0] m_out [2][CHANNELS][FRAME];
    bit m_busy, m_err, m_load, m_res, m_proc, m_to;
    int m_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_err = 0; m_load = 0; m_res = 0; m_t = 0;
        end else begin
            if (bus.wr_en)
                for (int j = 0; j < SPW; j++)
                    m_in[m_load][bus.wr_ch][int'(bus.wr_index) * SPW + j] =
                        bus.wr_data[j*SAMPLE_W +: SAMPLE_W];
            if (!m_busy) begin
                if (bus.start && !bus.abort) begin
                    m_proc = m_load; m_load = !m_load; m_err = 0;
                    m_busy = 1; m_t = 0; m_to = (eng_mode != 0);
                end
            end else if (bus.abort) m_busy = 0;
            else if (!m_to && m_t == RUN_LEN - 1) begin
                for (int ch = 0; ch < CHANNELS; ch++)
                    for (int s = 0; s < FRAME; s++) m_out[!m_res][ch][s] = m_in[m_proc][ch][s];
                m_res  = !m_res;
                m_busy = 0;
            end else if (m_to && m_t == TO_LEN - 1) begin
                m_busy = 0; m_err = 1;
            end else m_t++;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 0;
    bit c_done, c_ce;
    int c_ch, c_ph;
    logic [2*SAMPLE_W-1:0] c_smp;

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            c_done = m_busy && !m_to && (m_t == RUN_LEN - 1);
            c_ce   = m_busy && !c_done;
            c_ch   = m_to ? 0 : m_t / PERIOD;
            if (c_ch > CHANNELS - 1) c_ch = CHANNELS - 1;
            c_ph   = m_t % PERIOD;
            c_smp  = '0;
            if (c_ce && c_ph < FRAME) c_smp = {m_in[m_proc][c_ch][c_ph], 16'h0000};
            check("busy", 64'(bus.busy), 64'(m_busy));
            check("done", 64'(bus.done), 64'(c_done));
            check("error", 64'(bus.error), 64'(m_err));
            check("eng_ce", 64'(bus.eng_ce), 64'(c_ce));
            check("eng_sample", 64'(bus.eng_sample), 64'(c_smp));
            if (m_busy) check("cur_ch", 64'(bus.cur_ch), 64'(c_ch));
        end
    end

    // Cumulative event counters
    int busy_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD_W-1:0] ramp_word(input int base, input int w);
        logic [WORD_W-1:0] d;
        for (int j = 0; j < SPW; j++) d[j*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(base + w * SPW + j);
        return d;
    endfunction

    task automatic write_word(input int ch, input int w, input logic [WORD_W-1:0] d);
        bus.wr_en = 1'b1; bus.wr_ch = CW'(ch); bus.wr_index = IW'(w); bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic load_frame(input int ch, input int base);
        for (int w = 0; w < WORDS; w++) write_word(ch, w, ramp_word(base, w));
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 2000) begin
            tick();
            n++;
        end
        check(name, 64'(bus.busy), 64'd0);
    endtask

    task automatic read_word(input int ch, input int w, output logic [WORD_W-1:0] d);
        bus.rd_ch = CW'(ch); bus.rd_index = IW'(w);
        @(negedge clk);
        d = bus.rd_data;
        tick();
    endtask

    task automatic read_all(input string name);
        logic [WORD_W-1:0] e, a;
        for (int ch = 0; ch < CHANNELS; ch++)
            for (int w = 0; w < WORDS; w++) begin
                for (int j = 0; j < SPW; j++) e[j*SAMPLE_W +: SAMPLE_W] = m_out[m_res][ch][w*SPW + j];
                read_word(ch, w, a);
                check(name, a, e);
            end
    endtask

    // ---------------- directed scenarios ----------------
    int b0, d0;
    logic [WORD_W-1:0] rw;

    initial begin
        bus.start = 0; bus.abort = 0; bus.wr_en = 0; bus.wr_ch = '0;
        bus.wr_index = '0; bus.wr_data = '0; bus.rd_ch = '0; bus.rd_index = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_error", 64'(bus.error), 64'd0);
        check("rst_eng_ce", 64'(bus.eng_ce), 64'd0);
        check("rst_eng_sample", 64'(bus.eng_sample), 64'd0);
        rst_n = 1'b1;
        cmp_en = 1;
        tick();

        // Loopback: ramps 0..63 / 100..163
        load_frame(0, 0);
        load_frame(1, 100);
        b0 = busy_cnt; d0 = done_cnt;
        pulse_start();
        wait_idle("loop_idle");
        check("loop_busy_cycles", 64'(busy_cnt - b0), 64'd277);
        check("loop_done_count", 64'(done_cnt - d0), 64'd1);
        read_all("loop_rd");
        read_word(1, 0, rw);
        check("loop_ch1_w0", rw, 64'h0067_0066_0065_0064);
        read_word(0, 15, rw);
        check("loop_ch0_w15", rw, 64'h003F_003E_003D_003C);

        // Double buffering: frame A (with a write in the start cycle), B loaded while busy
        load_frame(0, 1000);
        load_frame(1, 2000);
        d0 = done_cnt;
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_ch = '0; bus.wr_index = '0;
        bus.wr_data = 64'h1111_2222_3333_4444;
        tick();
        bus.start = 1'b0; bus.wr_en = 1'b0;
        load_frame(0, 3000);
        load_frame(1, 4000);
        pulse_start();                      // ignored: already busy
        wait_idle("dbuf_a_idle");
        check("dbuf_a_done_count", 64'(done_cnt - d0), 64'd1);
        read_all("dbuf_a_rd");
        read_word(0, 0, rw);
        check("dbuf_a_start_write", rw, 64'h1111_2222_3333_4444);
        pulse_start();
        wait_idle("dbuf_b_idle");
        read_all("dbuf_b_rd");
        read_word(1, 1, rw);
        check("dbuf_b_ch1_w1", rw, 64'h0FA7_0FA6_0FA5_0FA4);

        // Abort mid-collect of channel 1
        load_frame(0, 5000);
        load_frame(1, 6000);
        d0 = done_cnt;
        pulse_start();
        repeat (PERIOD + FRAME + LAT + 20) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        read_word(1, 1, rw);
        check("abort_rd_kept", rw, 64'h0FA7_0FA6_0FA5_0FA4);

        // start together with abort in IDLE is dropped
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        tick();
        check("start_abort_idle", 64'(bus.busy), 64'd0);

        // Timeout: engine never syncs
        eng_mode = 1;
        b0 = busy_cnt; d0 = done_cnt;
        pulse_start();
        wait_idle("to_idle");
        check("to_busy_cycles", 64'(busy_cnt - b0), 64'd84);
        check("to_error", 64'(bus.error), 64'd1);
        check("to_no_done", 64'(done_cnt - d0), 64'd0);
        read_all("to_rd");
        eng_mode = 0;
        pulse_start();
        check("to_error_cleared", 64'(bus.error), 64'd0);
        wait_idle("post_to_idle");
        read_all("post_to_rd");

        // Asynchronous reset in the middle of channel 1 feed
        pulse_start();
        repeat (PERIOD + 2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_error", 64'(bus.error), 64'd0);
        check("arst_cur_ch", 64'(bus.cur_ch), 64'd0);
        check("arst_eng_ce", 64'(bus.eng_ce), 64'd0);
        check("arst_eng_sample", 64'(bus.eng_sample), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
